// File: rtl/mode_sequencer_pkg.sv
// dnn_ctrl_pkg: shared types and constants for the controller command sequencer
package dnn_ctrl_pkg;
  localparam int DEF_LEN_W = 16;
  localparam logic [31:0] MODE_IDLE = 32'h0;
  typedef enum logic [1:0] {IDLE, RUN, GAP} seq_state_t;
  typedef struct packed {
    logic [31:0] mode;
    logic [DEF_LEN_W-1:0] len;
  } cmd_t;
endpackage

// File: rtl/mode_sequencer_if.sv
// mode_sequencer_if: command queue and load-data handshakes feeding the sequencer
interface mode_sequencer_if #(parameter int LEN_W = dnn_ctrl_pkg::DEF_LEN_W) ();
  logic cmd_valid;
  logic cmd_ready;
  logic [31:0] cmd_mode;
  logic [LEN_W-1:0] cmd_len;
  logic data_valid;
  logic data_ready;
  logic signed [31:0] data_in;
  modport master (
    output cmd_valid, cmd_mode, cmd_len, data_valid, data_in,
    input cmd_ready, data_ready
  );
  modport slave (
    input cmd_valid, cmd_mode, cmd_len, data_valid, data_in,
    output cmd_ready, data_ready
  );
endinterface

// File: rtl/mode_sequencer_fifo.sv
// cmd_fifo: synchronous FIFO with flush; pointers carry a wrap bit for full/empty
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) wptr <= wptr + 1'b1;
      if (pop && !empty) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/mode_sequencer.sv
// mode_sequencer: plays queued {mode, len} commands onto the controller inputs,
// streaming load data and inserting idle mode-0 cycles between commands
module mode_sequencer import dnn_ctrl_pkg::*; #(
  parameter int CMD_DEPTH  = 4,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int GAP_CYCLES = 0,
  parameter int LOAD_BIT   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               abort,
  mode_sequencer_if.slave    bus,
  output logic               ctl_enable,
  output logic [31:0]        ctl_mode,
  output logic signed [31:0] ctl_data,
  output logic               busy,
  output logic               done_pulse
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  seq_state_t state, nxt_state;
  logic [31:0] cur_mode;
  logic [LEN_W-1:0] remaining;
  logic [GW-1:0] gap_cnt;
  logic [31+LEN_W:0] head;
  logic full, empty, push, pop, load, issue, last, gap_end, head_zero;
  logic nxt_enable, nxt_done;
  logic [31:0] nxt_mode;
  logic signed [31:0] nxt_data;
  assign bus.cmd_ready = !full && reset;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign load = cur_mode[LOAD_BIT];
  assign bus.data_ready = state == RUN && load && !abort;
  assign issue = state == RUN && (!load || (bus.data_valid && bus.data_ready));
  assign last = issue && remaining == LEN_W'(1);
  assign pop = state == IDLE && !empty && !abort;
  assign head_zero = head[LEN_W-1:0] == '0;
  assign gap_end = gap_cnt == GW'(GAP_CYCLES - 1);
  assign busy = state != IDLE || !empty;
  cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(32 + LEN_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .flush(abort),
    .push(push),
    .wr_data({bus.cmd_mode, bus.cmd_len}),
    .pop(pop),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt_state;
  always_comb begin
    nxt_state = state;
    if (abort) nxt_state = IDLE;
    else if (state == IDLE) nxt_state = pop && !head_zero ? RUN : IDLE;
    else if (state == RUN) nxt_state = last ? (GAP_CYCLES > 0 ? GAP : IDLE) : RUN;
    else nxt_state = gap_end ? IDLE : GAP;
  end
  // a stalled load beat drops enable but keeps the last mode/data on the bus
  always_comb begin
    nxt_enable = 1'b1;
    nxt_mode = MODE_IDLE;
    nxt_data = '0;
    nxt_done = 1'b0;
    if (!abort && state == RUN) begin
      nxt_enable = issue;
      nxt_mode = issue ? cur_mode : ctl_mode;
      nxt_data = issue ? (load ? bus.data_in : '0) : ctl_data;
      nxt_done = last;
    end else if (!abort && state == IDLE) begin
      nxt_done = pop && head_zero;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ctl_enable <= 1'b0;
      ctl_mode <= MODE_IDLE;
      ctl_data <= '0;
      done_pulse <= 1'b0;
      cur_mode <= MODE_IDLE;
      remaining <= '0;
      gap_cnt <= '0;
    end else begin
      ctl_enable <= nxt_enable;
      ctl_mode <= nxt_mode;
      ctl_data <= nxt_data;
      done_pulse <= nxt_done;
      cur_mode <= pop ? head[31+LEN_W:LEN_W] : cur_mode;
      remaining <= abort ? '0 : pop ? head[LEN_W-1:0] : issue ? remaining - 1'b1 : remaining;
      gap_cnt <= state == GAP ? gap_cnt + 1'b1 : '0;
    end
endmodule

// File: tb/tb_mode_sequencer.sv
// tb_mode_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_mode_sequencer;
  typedef struct {
    logic cv; logic [31:0] m; logic [15:0] l;
    logic dv; logic signed [31:0] di;
    logic dr; logic en; logic [31:0] em; logic signed [31:0] ed; logic dn; logic by;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic abort = 1'b0;
  logic ctl_enable, busy, done_pulse;
  logic [31:0] ctl_mode;
  logic signed [31:0] ctl_data;
  int checks = 0;
  int errors = 0;
  vec_t tv[23];
  logic [31:0] modes[3] = '{32'h1401, 32'h2411, 32'h0023};
  int lens[3] = '{96, 96, 256};
  int beats[3];
  int dones, zrun, gap_bad, dr_seen, en_low, n, bad;
  logic [31:0] prev_nz;
  mode_sequencer_if #(.LEN_W(16)) bus();
  mode_sequencer #(.CMD_DEPTH(4), .LEN_W(16), .GAP_CYCLES(0), .LOAD_BIT(8)) dut (
    .clk(clk), .reset(reset), .abort(abort), .bus(bus),
    .ctl_enable(ctl_enable), .ctl_mode(ctl_mode), .ctl_data(ctl_data),
    .busy(busy), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic cv, logic [31:0] m, logic [15:0] l, logic dv, logic signed [31:0] di,
                              logic dr, logic en, logic [31:0] em, logic signed [31:0] ed, logic dn, logic by);
    vec_t v;
    v.cv = cv; v.m = m; v.l = l; v.dv = dv; v.di = di;
    v.dr = dr; v.en = en; v.em = em; v.ed = ed; v.dn = dn; v.by = by;
    return v;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic v, input logic [31:0] m, input logic [15:0] l);
    bus.cmd_valid = v;
    bus.cmd_mode = m;
    bus.cmd_len = l;
  endtask
  initial begin
    cmd(0, 0, 0);
    bus.data_valid = 0;
    bus.data_in = 0;
    tv[0]  = mk(1, 32'h142, 4, 0, 0,  0, 1, 0, 0, 0, 1);
    tv[1]  = mk(0, 0, 0,       1, 1,  0, 1, 0, 0, 0, 1);
    tv[2]  = mk(0, 0, 0,       1, 1,  1, 1, 32'h142, 1, 0, 1);
    tv[3]  = mk(0, 0, 0,       1, 0,  1, 1, 32'h142, 0, 0, 1);
    tv[4]  = mk(0, 0, 0,       1, 1,  1, 1, 32'h142, 1, 0, 1);
    tv[5]  = mk(0, 0, 0,       1, 1,  1, 1, 32'h142, 1, 1, 0);
    tv[6]  = mk(0, 0, 0,       1, 7,  0, 1, 0, 0, 0, 0);
    tv[7]  = mk(1, 32'h102, 3, 0, 0,  0, 1, 0, 0, 0, 1);
    tv[8]  = mk(0, 0, 0,       1, 5,  0, 1, 0, 0, 0, 1);
    tv[9]  = mk(0, 0, 0,       1, 5,  1, 1, 32'h102, 5, 0, 1);
    tv[10] = mk(0, 0, 0,       0, 9,  1, 0, 32'h102, 5, 0, 1);
    tv[11] = mk(0, 0, 0,       0, 9,  1, 0, 32'h102, 5, 0, 1);
    tv[12] = mk(0, 0, 0,       1, -3, 1, 1, 32'h102, -3, 0, 1);
    tv[13] = mk(0, 0, 0,       1, 6,  1, 1, 32'h102, 6, 1, 0);
    tv[14] = mk(0, 0, 0,       0, 0,  0, 1, 0, 0, 0, 0);
    tv[15] = mk(1, 32'h23, 2,  0, 0,  0, 1, 0, 0, 0, 1);
    tv[16] = mk(0, 0, 0,       1, 4,  0, 1, 0, 0, 0, 1);
    tv[17] = mk(0, 0, 0,       1, 4,  0, 1, 32'h23, 0, 0, 1);
    tv[18] = mk(0, 0, 0,       1, 4,  0, 1, 32'h23, 0, 1, 0);
    tv[19] = mk(0, 0, 0,       0, 0,  0, 1, 0, 0, 0, 0);
    tv[20] = mk(1, 32'h23, 0,  0, 0,  0, 1, 0, 0, 0, 1);
    tv[21] = mk(0, 0, 0,       0, 0,  0, 1, 0, 0, 1, 0);
    tv[22] = mk(0, 0, 0,       0, 0,  0, 1, 0, 0, 0, 0);
    #2;
    check("rst enable", ctl_enable, 0);
    check("rst mode", ctl_mode, 0);
    check("rst data", ctl_data, 0);
    check("rst done", done_pulse, 0);
    check("rst busy", busy, 0);
    check("rst cmd_ready", bus.cmd_ready, 0);
    tick; tick;
    check("rst hold enable", ctl_enable, 0);
    reset = 1;
    #1;
    check("post-rst cmd_ready", bus.cmd_ready, 1);
    tick;
    check("idle enable", ctl_enable, 1);
    check("idle mode", ctl_mode, 0);
    for (int i = 0; i < 23; i++) begin
      cmd(tv[i].cv, tv[i].m, tv[i].l);
      bus.data_valid = tv[i].dv;
      bus.data_in = tv[i].di;
      #1;
      check($sformatf("row%0d data_ready", i), bus.data_ready, tv[i].dr);
      tick;
      check($sformatf("row%0d enable", i), ctl_enable, tv[i].en);
      check($sformatf("row%0d mode", i), ctl_mode, tv[i].em);
      check($sformatf("row%0d data", i), ctl_data, tv[i].ed);
      check($sformatf("row%0d done", i), done_pulse, tv[i].dn);
      check($sformatf("row%0d busy", i), busy, tv[i].by);
    end
    cmd(0, 0, 0);
    bus.data_valid = 0;
    // back-to-back non-load commands
    beats = '{0, 0, 0};
    dones = 0; zrun = 0; gap_bad = 0; dr_seen = 0; en_low = 0; prev_nz = 0;
    for (int c = 0; c < 1000 && dones < 3; c++) begin
      if (c < 3) cmd(1, modes[c], 16'(lens[c]));
      else cmd(0, 0, 0);
      #1;
      if (bus.data_ready) dr_seen++;
      tick;
      if (done_pulse) dones++;
      if (!ctl_enable) en_low++;
      if (ctl_mode == 0) zrun++;
      else begin
        if (prev_nz != 0 && prev_nz != ctl_mode && zrun != 1) gap_bad++;
        if (prev_nz == ctl_mode && zrun != 0) gap_bad++;
        zrun = 0;
        prev_nz = ctl_mode;
        for (int k = 0; k < 3; k++) if (ctl_mode == modes[k]) beats[k]++;
      end
    end
    cmd(0, 0, 0);
    check("b2b beats 1401", beats[0], 96);
    check("b2b beats 2411", beats[1], 96);
    check("b2b beats 0023", beats[2], 256);
    check("b2b dones", dones, 3);
    check("b2b gap cycles", gap_bad, 0);
    check("b2b data_ready", dr_seen, 0);
    check("b2b enable low", en_low, 0);
    tick;
    // fill the FIFO behind a long command
    cmd(1, 32'h1401, 96);
    tick;
    cmd(0, 0, 0);
    tick;
    for (int k = 0; k < 4; k++) begin
      cmd(1, 32'h2411, 3);
      tick;
      check($sformatf("fill%0d cmd_ready", k), bus.cmd_ready, k < 3);
    end
    cmd(0, 0, 0);
    n = 0;
    while (!done_pulse && n < 200) begin
      tick;
      n++;
    end
    check("fill long done", done_pulse, 1);
    check("full at done cmd_ready", bus.cmd_ready, 0);
    tick;
    check("after pop cmd_ready", bus.cmd_ready, 1);
    dones = 0; n = 0;
    while (busy && n < 100) begin
      tick;
      n++;
      if (done_pulse) dones++;
    end
    check("drain dones", dones, 4);
    check("drain busy", busy, 0);
    // abort with two commands queued and a push on the abort edge
    cmd(1, 32'h1401, 96);
    tick;
    cmd(0, 0, 0);
    tick;
    n = 0; bad = 0;
    while (bad < 10 && n < 50) begin
      if (bad == 0) cmd(1, 32'h2411, 10);
      else if (bad == 1) cmd(1, 32'h0023, 10);
      else cmd(0, 0, 0);
      tick;
      n++;
      if (ctl_enable && ctl_mode == 32'h1401) bad++;
    end
    check("abort beats before", bad, 10);
    cmd(1, 32'h0142, 5);
    abort = 1;
    tick;
    abort = 0;
    cmd(0, 0, 0);
    check("abort mode", ctl_mode, 0);
    check("abort enable", ctl_enable, 1);
    check("abort done", done_pulse, 0);
    check("abort busy", busy, 0);
    check("abort cmd_ready", bus.cmd_ready, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (ctl_mode != 0 || done_pulse) bad++;
    end
    check("abort quiet", bad, 0);
    // asynchronous reset during a run
    cmd(1, 32'h1401, 96);
    tick;
    cmd(0, 0, 0);
    tick; tick; tick;
    check("pre-reset mode", ctl_mode, 32'h1401);
    #3;
    reset = 0;
    #1;
    check("midrst enable", ctl_enable, 0);
    check("midrst mode", ctl_mode, 0);
    check("midrst data", ctl_data, 0);
    check("midrst cmd_ready", bus.cmd_ready, 0);
    tick; tick;
    reset = 1;
    #1;
    check("rst release busy", busy, 0);
    check("rst release cmd_ready", bus.cmd_ready, 1);
    tick;
    check("rst release enable", ctl_enable, 1);
    check("rst release mode", ctl_mode, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
